// File: rtl/if_prefetch_queue_if.sv
// ----------------------------------------------------------------------------
// if_prefetch_queue_if
// Purpose : groups the branch-redirect, instruction-memory and ID-side
//           handshake signals of the prefetch queue into one bundle.
// Signals :
//   br_taken / br_addr            EX redirect into the queue
//   imem_req_valid/ready, addr    in-order read request toward memory
//   imem_rsp_valid, rsp_data      in-order read data from memory
//   out_valid/ready, inst, pc     head entry toward ID (pc = address + 4)
// Modports:
//   master : the prefetch queue itself
//   slave  : the environment (EX, memory and ID sides)
// ----------------------------------------------------------------------------
interface if_prefetch_queue_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              br_taken;
  logic [ADDR_W-1:0] br_addr;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rsp_valid;
  logic [DATA_W-1:0] imem_rsp_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_inst;
  logic [ADDR_W-1:0] out_pc;

  modport master (
    input  br_taken, br_addr,
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output out_valid, out_inst, out_pc,
    input  out_ready
  );

  modport slave (
    output br_taken, br_addr,
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  out_valid, out_inst, out_pc,
    output out_ready
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// ----------------------------------------------------------------------------
// if_prefetch_queue
// Purpose : instruction prefetch queue between a variable-latency memory port
//           and the ID stage. Issues in-order reads under a credit limit of
//           DEPTH (stored + live + stale reads), buffers returned instructions
//           with their PC+4, and flushes/squashes everything on a taken branch.
// Ports   :
//   clk   pipeline clock, rising edge
//   rst   asynchronous reset, active-high (memory shares it)
//   bus   if_prefetch_queue_if.master (redirect, memory and ID handshakes)
//   stat_squash_cnt  [15:0] saturating squashed-instruction count
//                    (present only when PFQ_STATS_EN is defined)
// Optional feature macro: PFQ_STATS_EN
// ----------------------------------------------------------------------------
module if_prefetch_queue #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  if_prefetch_queue_if.master    bus
`ifdef PFQ_STATS_EN
  ,
  output logic [15:0]            stat_squash_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Credit sum needs two extra bits: three CW-bit counters added together.
  localparam int SW = CW + 2;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_rsp_pc;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     r_inflight;
  logic [CW-1:0]     r_drop;
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [DATA_W-1:0] r_mem_inst [DEPTH];
  logic [ADDR_W-1:0] r_mem_pc   [DEPTH];

  logic [SW-1:0]     w_credit_used;
  logic              w_pending;
  logic              w_rsp_ok;
  logic              w_req_valid;
  logic              w_fire;
  logic              w_drop_rsp;
  logic              w_push;
  logic              w_pop;

  assign w_credit_used = SW'(r_count) + SW'(r_inflight) + SW'(r_drop);
  assign w_pending     = (r_inflight != '0) || (r_drop != '0);
  // A response with nothing outstanding is illegal; it is simply ignored.
  assign w_rsp_ok      = bus.imem_rsp_valid && w_pending;
  assign w_req_valid   = !rst && !bus.br_taken && (w_credit_used < SW'(DEPTH));
  assign w_fire        = w_req_valid && bus.imem_req_ready;
  // Stale reads are always older than live ones, so they are retired first.
  assign w_drop_rsp    = w_rsp_ok && (r_drop != '0);
  assign w_push        = w_rsp_ok && (r_drop == '0);
  assign w_pop         = (r_count != '0) && bus.out_ready;

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_addr      = r_fetch_pc;
  assign bus.out_valid      = (r_count != '0);
  assign bus.out_inst       = r_mem_inst[r_head];
  assign bus.out_pc         = r_mem_pc[r_head];

  // Control state: fetch/response PCs, counters and queue pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_count    <= '0;
      r_inflight <= '0;
      r_drop     <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else if (bus.br_taken) begin
      // Live reads become stale; a response arriving now retires one of them.
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_inflight <= '0;
      r_drop     <= r_drop + r_inflight - CW'(w_rsp_ok);
      r_fetch_pc <= bus.br_addr;
      r_rsp_pc   <= bus.br_addr;
    end else begin
      if (w_fire) begin
        r_fetch_pc <= r_fetch_pc + PC_STEP;
      end
      r_inflight <= r_inflight + CW'(w_fire) - CW'(w_push);
      if (w_drop_rsp) begin
        r_drop <= r_drop - CW'(1'b1);
      end
      if (w_push) begin
        r_tail   <= r_tail + PW'(1'b1);
        r_rsp_pc <= r_rsp_pc + PC_STEP;
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1'b1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Entry storage: instruction plus its PC+4, written at the tail.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_inst[i] <= '0;
        r_mem_pc[i]   <= '0;
      end
    end else if (w_push && !bus.br_taken) begin
      r_mem_inst[r_tail] <= bus.imem_rsp_data;
      r_mem_pc[r_tail]   <= r_rsp_pc + PC_STEP;
    end
  end

`ifdef PFQ_STATS_EN
  logic [15:0] r_squash_cnt;
  logic [CW:0] w_squash_inc;
  logic [16:0] w_squash_sum;

  // Squashed this cycle: flushed entries (+ a response killed by the flush),
  // or one stale response discarded.
  always_comb begin
    w_squash_inc = '0;
    if (bus.br_taken) begin
      w_squash_inc = {1'b0, r_count} + (CW+1)'(w_rsp_ok);
    end else if (w_drop_rsp) begin
      w_squash_inc = (CW+1)'(1'b1);
    end else begin
      w_squash_inc = '0;
    end
    w_squash_sum = {1'b0, r_squash_cnt} + 17'(w_squash_inc);
  end

  // Saturating squash counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_squash_cnt <= 16'h0000;
    end else if (w_squash_sum[16]) begin
      r_squash_cnt <= 16'hFFFF;
    end else begin
      r_squash_cnt <= w_squash_sum[15:0];
    end
  end

  assign stat_squash_cnt = r_squash_cnt;
`endif

  if_prefetch_queue_chk u_chk (
    .clk        (clk),
    .rst        (rst),
    .i_rsp_valid(bus.imem_rsp_valid),
    .i_pending  (w_pending)
  );

endmodule

// Protocol checker: memory must not return data with no read outstanding.
module if_prefetch_queue_chk (
  input logic clk,
  input logic rst,
  input logic i_rsp_valid,
  input logic i_pending
);
  // Check every clock outside reset for an unsolicited response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(i_rsp_valid && !i_pending))
        else $error("if_prefetch_queue: response with no outstanding read");
    end
  end
endmodule
